hdmi_i2c_sequencer: RTL and testbench
=====================================

// Module: hdmi_i2c_sequencer
// PURPOSE
//  Controller for the I2C byte-write engine that configures the HDMI transmitter.
//  Walks a 24-bit config table (slave addr | reg addr | data) and issues one engine transaction per entry.
//  Retries on NACK and re-runs the table on start_n or on a debounced hot-plug.
//  Arbitrates runtime host register writes onto the same engine. Sits between the config ROM, the host and the engine.
// PARAMETERS
//  TABLE_LEN      20    number of table entries (index 0..TABLE_LEN-1)
//  ADDR_W         6     table index width
//  MAX_ATTEMPTS   3     total engine attempts per word (first try + retries)
//  GAP_CYCLES     16    idle cycles enforced between consecutive engine transactions
//  HPD_DB_CYCLES  256   cycles hpd must stay high before a boot is triggered
// PORTS
//  clock           in   1       system clock; all logic on posedge
//  reset_n         in   1       synchronous, active-low reset
//  start_n         in   1       active-low boot request (level, sampled each posedge)
//  hpd             in   1       hot-plug detect from HDMI connector
//  tbl_addr        out  ADDR_W  config ROM index
//  tbl_data        in   24      ROM word; valid the cycle after tbl_addr changes
//  host_req_valid  in   1       host write request
//  host_req_ready  out  1       host request accepted when valid & ready
//  host_req_data   in   24      host word {slave, reg, data}
//  host_rsp_valid  out  1       1-cycle pulse: host write finished
//  host_rsp_err    out  1       qualifies host_rsp_valid: all attempts NACKed
//  eng_cmd_valid   out  1       command to engine
//  eng_cmd_ready   in   1       engine idle; handshake on valid & ready
//  eng_cmd_data    out  24      word for engine; stable while eng_cmd_valid
//  eng_done        in   1       1-cycle pulse: engine STOP complete
//  eng_nack        in   1       sampled with eng_done; 1 = slave NACK
//  init_done       out  1       table completed without fault
//  busy            out  1       state != IDLE
//  fault           out  1       boot aborted after MAX_ATTEMPTS NACKs
//  fault_index     out  ADDR_W  table index that faulted
// BEHAVIOUR
//  Reset: state IDLE; every output 0; boot_pending, retry count, hpd debounce counter cleared.
//  Reset mid-operation: IDLE on the next edge. The engine shares reset_n.
//  States: IDLE, FETCH, LATCH, ISSUE, WAIT, GAP, HOST_ISSUE, HOST_WAIT.
//  Boot trigger:
//   - Sets boot_pending when start_n==0, or when hpd has been high for HPD_DB_CYCLES consecutive cycles after being low.
//   - Any hpd low resets the debounce counter and clears init_done.
//  IDLE:
//   - If boot_pending: clear boot_pending, fault and init_done; set idx=0; go to FETCH.
//   - Else host_req_ready=1 (combinational in IDLE only). On host handshake, capture data and go to HOST_ISSUE.
//   - Boot has strict priority over host.
//  FETCH: drive tbl_addr=idx; go to LATCH.
//  LATCH:
//   - Capture tbl_data into eng_cmd_data and clear the attempt count.
//   - If the word is 24'hFFFFFF (end marker), set init_done and go to IDLE.
//   - Else go to ISSUE.
//  ISSUE:
//   - eng_cmd_valid=1 until the cycle with eng_cmd_ready=1; then deassert and go to WAIT.
//  WAIT: wait for eng_done. eng_done outside WAIT/HOST_WAIT is ignored.
//   - ack, idx==TABLE_LEN-1: init_done=1, go to IDLE (no GAP).
//   - ack, otherwise: idx+1, go to GAP, then FETCH.
//   - nack, attempts<MAX_ATTEMPTS: attempts+1, go to GAP, reissue the same word.
//   - nack, final attempt: fault=1, fault_index=idx, go to IDLE. Remaining entries are not issued.
//  GAP: counts GAP_CYCLES cycles with eng_cmd_valid=0.
//  Boot trigger while busy:
//   - Sets boot_pending. The current engine transaction always completes; there is no mid-frame abort.
//   - During a boot, pending restarts at idx 0 when WAIT resolves.
//   - During host work, pending is serviced from IDLE after the response.
//  HOST_ISSUE/HOST_WAIT: same handshake and retry rules as ISSUE/WAIT.
//   - Ends with a host_rsp_valid pulse (err=1 if the final attempt NACKed).
//   - Inserts GAP_CYCLES before returning to IDLE.
//   - Does not touch init_done, fault or fault_index.
//  Engine commands are spaced at least GAP_CYCLES apart.
// TESTING
//  T1 start_n pulse, 20-entry table, engine ACKs all -> 20 handshakes with data = ROM[0..19] in order, gaps >=16, init_done=1.
//  T2 NACK entry 5 twice, then ACK -> entry 5 issued 3x with identical data, entries 6..19 follow, init_done=1, fault=0.
//  T3 NACK entry 7 three times -> fault=1, fault_index=7, no 8th-entry command, init_done=0, busy=0.
//  T4 host 24'h724110 after init -> ready=1, one command 24'h724110, rsp_valid pulse, err=0; host req during boot -> ready=0 until boot ends.
//  T5 hpd high 100 cycles then low -> no boot; high 256 cycles -> boot from idx 0; hpd low -> init_done=0.
//  T6 ROM[3]=24'hFFFFFF -> 3 commands, init_done=1; reset_n=0 during WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hdmi_i2c_sequencer_if.sv
// Host request/response and engine command channels of the HDMI config sequencer.
// Handshake: a transfer happens on the posedge where valid & ready are both 1; the
// initiator holds valid and data stable until then, and ready never waits on valid.
interface hdmi_i2c_sequencer_if;
   logic        host_req_valid;
   logic        host_req_ready;
   logic [23:0] host_req_data;
   logic        host_rsp_valid;
   logic        host_rsp_err;
   logic        eng_cmd_valid;
   logic        eng_cmd_ready;
   logic [23:0] eng_cmd_data;
   logic        eng_done;
   logic        eng_nack;

   modport master (
      input  host_req_valid, host_req_data, eng_cmd_ready, eng_done, eng_nack,
      output host_req_ready, host_rsp_valid, host_rsp_err, eng_cmd_valid, eng_cmd_data
   );

   modport slave (
      output host_req_valid, host_req_data, eng_cmd_ready, eng_done, eng_nack,
      input  host_req_ready, host_rsp_valid, host_rsp_err, eng_cmd_valid, eng_cmd_data
   );
endinterface

// File: rtl/hdmi_i2c_sequencer.sv
// Walks the HDMI transmitter config table through the I2C byte-write engine, with
// NACK retries, hot-plug/start_n re-boot and arbitration of host register writes.
module hdmi_i2c_sequencer #(
   parameter int TABLE_LEN     = 20,
   parameter int ADDR_W        = 6,
   parameter int MAX_ATTEMPTS  = 3,
   parameter int GAP_CYCLES    = 16,
   parameter int HPD_DB_CYCLES = 256
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start_n,
   input  logic              hpd,
   output logic [ADDR_W-1:0] tbl_addr,
   input  logic [23:0]       tbl_data,
   hdmi_i2c_sequencer_if.master bus,
   output logic              init_done,
   output logic              busy,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_index,
   output logic [2:0]        state_dbg
);

   localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int HPD_W = $clog2(HPD_DB_CYCLES);
   localparam logic [23:0] END_MARK = 24'hFFFFFF;

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_FETCH      = 3'd1;
   localparam logic [2:0] S_LATCH      = 3'd2;
   localparam logic [2:0] S_ISSUE      = 3'd3;
   localparam logic [2:0] S_WAIT       = 3'd4;
   localparam logic [2:0] S_GAP        = 3'd5;
   localparam logic [2:0] S_HOST_ISSUE = 3'd6;
   localparam logic [2:0] S_HOST_WAIT  = 3'd7;

   logic [2:0]        state;
   logic [2:0]        gap_next;
   logic [ADDR_W-1:0] idx;
   logic [ATT_W-1:0]  att;
   logic [GAP_W-1:0]  gap_cnt;
   logic [HPD_W-1:0]  hpd_cnt;
   logic              hpd_armed;
   logic              boot_pending;
   logic              retry_ok;

   // The index register drives the ROM directly, so the address is always settled
   // for at least the FETCH cycle before LATCH samples the registered ROM output.
   assign tbl_addr  = idx;
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;
   assign retry_ok  = (32'(att) + 1 < MAX_ATTEMPTS);

   assign bus.eng_cmd_valid  = (state == S_ISSUE) || (state == S_HOST_ISSUE);
   assign bus.host_req_ready = reset_n && (state == S_IDLE) && !boot_pending && (gap_cnt == '0);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state              <= S_IDLE;
         gap_next           <= S_IDLE;
         idx                <= '0;
         att                <= '0;
         gap_cnt            <= '0;
         hpd_cnt            <= '0;
         hpd_armed          <= 1'b0;
         boot_pending       <= 1'b0;
         init_done          <= 1'b0;
         fault              <= 1'b0;
         fault_index        <= '0;
         bus.eng_cmd_data   <= '0;
         bus.host_rsp_valid <= 1'b0;
         bus.host_rsp_err   <= 1'b0;
      end else begin
         bus.host_rsp_valid <= 1'b0;
         bus.host_rsp_err   <= 1'b0;
         // gap_cnt runs from every engine completion, so IDLE also honours the spacing
         if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

         case (state)
            S_IDLE: begin
               if (boot_pending) begin
                  if (gap_cnt == '0) begin
                     boot_pending <= 1'b0;
                     fault        <= 1'b0;
                     init_done    <= 1'b0;
                     idx          <= '0;
                     state        <= S_FETCH;
                  end
               end else if (bus.host_req_valid && bus.host_req_ready) begin
                  bus.eng_cmd_data <= bus.host_req_data;
                  att              <= '0;
                  state            <= S_HOST_ISSUE;
               end
            end
            S_FETCH: state <= S_LATCH;
            S_LATCH: begin
               bus.eng_cmd_data <= tbl_data;
               att              <= '0;
               if (tbl_data == END_MARK) begin
                  init_done <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: if (bus.eng_cmd_ready) state <= S_WAIT;
            S_WAIT: begin
               if (bus.eng_done) begin
                  gap_cnt <= GAP_W'(GAP_CYCLES);
                  if (boot_pending) begin
                     boot_pending <= 1'b0;
                     fault        <= 1'b0;
                     init_done    <= 1'b0;
                     idx          <= '0;
                     gap_next     <= S_FETCH;
                     state        <= S_GAP;
                  end else if (!bus.eng_nack) begin
                     if (idx == ADDR_W'(TABLE_LEN - 1)) begin
                        init_done <= 1'b1;
                        state     <= S_IDLE;
                     end else begin
                        idx      <= idx + 1'b1;
                        gap_next <= S_FETCH;
                        state    <= S_GAP;
                     end
                  end else if (retry_ok) begin
                     att      <= att + 1'b1;
                     gap_next <= S_ISSUE;
                     state    <= S_GAP;
                  end else begin
                     fault       <= 1'b1;
                     fault_index <= idx;
                     state       <= S_IDLE;
                  end
               end
            end
            S_GAP: if (gap_cnt <= GAP_W'(1)) state <= gap_next;
            S_HOST_ISSUE: if (bus.eng_cmd_ready) state <= S_HOST_WAIT;
            S_HOST_WAIT: begin
               if (bus.eng_done) begin
                  gap_cnt <= GAP_W'(GAP_CYCLES);
                  state   <= S_GAP;
                  if (bus.eng_nack && retry_ok) begin
                     att      <= att + 1'b1;
                     gap_next <= S_HOST_ISSUE;
                  end else begin
                     bus.host_rsp_valid <= 1'b1;
                     bus.host_rsp_err   <= bus.eng_nack;
                     gap_next           <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase

         // Boot triggers come last so a new request is never lost to a same-cycle clear.
         if (!hpd) begin
            hpd_cnt   <= '0;
            hpd_armed <= 1'b1;
            init_done <= 1'b0;
         end else if (hpd_armed) begin
            if (hpd_cnt == HPD_W'(HPD_DB_CYCLES - 1)) begin
               hpd_cnt      <= '0;
               hpd_armed    <= 1'b0;
               boot_pending <= 1'b1;
            end else begin
               hpd_cnt <= hpd_cnt + 1'b1;
            end
         end
         if (!start_n) boot_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hdmi_i2c_sequencer.sv
// Self-checking bench for hdmi_i2c_sequencer: ROM + engine models, command scoreboard.
module tb_hdmi_i2c_sequencer;
   localparam int GAP = 16;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_n = 1'b1;
   logic        hpd = 1'b0;
   logic [5:0]  tbl_addr;
   logic [23:0] tbl_data = '0;
   logic        init_done, busy, fault;
   logic [5:0]  fault_index;
   logic [2:0]  state_dbg;

   hdmi_i2c_sequencer_if bus ();

   hdmi_i2c_sequencer dut (
      .clock(clock), .reset_n(reset_n), .start_n(start_n), .hpd(hpd),
      .tbl_addr(tbl_addr), .tbl_data(tbl_data), .bus(bus),
      .init_done(init_done), .busy(busy), .fault(fault),
      .fault_index(fault_index), .state_dbg(state_dbg)
   );

   // clock / reset block
   always #5 clock = ~clock;

   logic [23:0] rom [0:63];
   always @(posedge clock) tbl_data <= rom[tbl_addr];

   // scoreboard state
   logic [23:0] exp_q [$];
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // engine model
   logic [23:0] nack_word = '0;
   int          nack_left = 0;
   int          eng_timer = 0;
   bit          eng_busy = 0;
   bit          eng_nack_now = 0;
   bit          gap_track = 0;
   int          idle_run = 0;

   initial begin
      bus.eng_cmd_ready = 1'b1;
      bus.eng_done      = 1'b0;
      bus.eng_nack      = 1'b0;
      forever begin
         @(negedge clock);
         bus.eng_done = 1'b0;
         bus.eng_nack = 1'b0;
         if (!reset_n) begin
            eng_busy = 0;
            gap_track = 0;
            bus.eng_cmd_ready = 1'b1;
         end else if (eng_busy) begin
            bus.eng_cmd_ready = 1'b0;
            eng_timer--;
            if (eng_timer == 0) begin
               bus.eng_done = 1'b1;
               bus.eng_nack = eng_nack_now;
               bus.eng_cmd_ready = 1'b1;
               eng_busy = 0;
               gap_track = 1;
               idle_run = 0;
            end
         end else if (bus.eng_cmd_valid && bus.eng_cmd_ready) begin
            if (gap_track) check("cmd_gap", 32'(idle_run >= GAP), 1);
            check("cmd_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("cmd_data", 32'(bus.eng_cmd_data), 32'(exp_q.pop_front()));
            eng_nack_now = (nack_left > 0) && (bus.eng_cmd_data == nack_word);
            if (eng_nack_now) nack_left--;
            eng_busy = 1;
            eng_timer = 4;
         end else if (!bus.eng_cmd_valid) begin
            idle_run++;
         end
      end
   end

   // driver tasks
   task automatic push_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) exp_q.push_back(rom[i]);
   endtask

   task automatic pulse_start();
      start_n = 1'b0;
      @(negedge clock);
      start_n = 1'b1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!busy && n < budget) begin @(negedge clock); n++; end
      while (busy && n < budget) begin @(negedge clock); n++; end
      check(tag, 32'(n < budget), 1);
   endtask

   task automatic host_write(input logic [23:0] w, input logic exp_err, input int budget);
      int n;
      bit hs, got;
      n = 0; hs = 0; got = 0;
      bus.host_req_data = w;
      bus.host_req_valid = 1'b1;
      while (!got && n < budget) begin
         if (bus.host_req_valid) begin
            if (hs) bus.host_req_valid = 1'b0;
            else if (bus.host_req_ready) begin
               hs = 1;
               check("host_hs_init_done", 32'(init_done), 1);
            end
         end
         if (bus.host_rsp_valid) begin
            got = 1;
            check("host_rsp_err", 32'(bus.host_rsp_err), 32'(exp_err));
         end
         @(negedge clock);
         n++;
      end
      bus.host_req_valid = 1'b0;
      check("host_rsp_seen", 32'(got), 1);
      check("host_rsp_pulse", 32'(bus.host_rsp_valid), 0);
   endtask

   initial begin
      int n;
      bit saw_busy;
      bus.host_req_valid = 1'b0;
      bus.host_req_data  = '0;
      for (int i = 0; i < 64; i++) rom[i] = 24'h0;
      for (int i = 0; i < 20; i++)
         rom[i] = {8'h72, 8'(i + 16), 8'($urandom_range(0, 255))};

      repeat (4) @(negedge clock);
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(bus.eng_cmd_valid), 0);
      check("rst_ready", 32'(bus.host_req_ready), 0);
      reset_n = 1'b1;
      @(negedge clock);
      check("idle_init_done", 32'(init_done), 0);
      check("idle_fault", 32'(fault), 0);
      check("idle_tbl_addr", 32'(tbl_addr), 0);
      check("idle_host_ready", 32'(bus.host_req_ready), 1);

      // short hot-plug pulse must not boot
      hpd = 1'b1;
      saw_busy = 0;
      for (int i = 0; i < 100; i++) begin @(negedge clock); if (busy) saw_busy = 1; end
      hpd = 1'b0;
      repeat (5) @(negedge clock);
      check("hpd_short_no_boot", 32'(saw_busy), 0);

      // debounced hot-plug boots the full table
      push_range(0, 19);
      hpd = 1'b1;
      n = 0;
      while (!busy && n < 400) begin @(negedge clock); n++; end
      check("hpd_boot_latency", 32'(n >= 256 && n <= 258), 1);
      wait_done("hpd_boot_done", 2000);
      check("hpd_boot_init_done", 32'(init_done), 1);
      check("hpd_boot_drained", 32'(exp_q.size()), 0);

      // start_n boot, all ACK
      push_range(0, 19);
      pulse_start();
      wait_done("t1_done", 2000);
      check("t1_init_done", 32'(init_done), 1);
      check("t1_fault", 32'(fault), 0);
      check("t1_drained", 32'(exp_q.size()), 0);

      // entry 5 NACKed twice then ACKed
      nack_word = rom[5]; nack_left = 2;
      push_range(0, 5); push_range(5, 5); push_range(5, 19);
      pulse_start();
      wait_done("t2_done", 2000);
      check("t2_init_done", 32'(init_done), 1);
      check("t2_fault", 32'(fault), 0);
      check("t2_drained", 32'(exp_q.size()), 0);

      // entry 7 NACKed on every attempt
      nack_word = rom[7]; nack_left = 3;
      push_range(0, 7); push_range(7, 7); push_range(7, 7);
      pulse_start();
      wait_done("t3_done", 2000);
      repeat (60) @(negedge clock);
      check("t3_fault", 32'(fault), 1);
      check("t3_fault_index", 32'(fault_index), 7);
      check("t3_init_done", 32'(init_done), 0);
      check("t3_busy", 32'(busy), 0);
      check("t3_drained", 32'(exp_q.size()), 0);

      // re-init, then host writes
      push_range(0, 19);
      pulse_start();
      wait_done("t4_boot_done", 2000);
      check("t4_fault_cleared", 32'(fault), 0);
      exp_q.push_back(24'h724110);
      host_write(24'h724110, 1'b0, 200);
      wait_done("t4_host_gap", 200);
      check("t4_host_drained", 32'(exp_q.size()), 0);

      nack_word = 24'h724333; nack_left = 3;
      exp_q.push_back(24'h724333); exp_q.push_back(24'h724333); exp_q.push_back(24'h724333);
      host_write(24'h724333, 1'b1, 400);
      wait_done("t4_nack_gap", 200);
      check("t4_nack_init_kept", 32'(init_done), 1);
      check("t4_nack_fault_kept", 32'(fault), 0);

      // host request raised while a boot is pending must wait for the boot
      push_range(0, 19);
      exp_q.push_back(24'h724222);
      pulse_start();
      host_write(24'h724222, 1'b0, 3000);
      wait_done("t4_late_gap", 200);
      check("t4_late_drained", 32'(exp_q.size()), 0);

      // end marker at entry 3
      rom[3] = 24'hFFFFFF;
      push_range(0, 2);
      pulse_start();
      wait_done("t6_marker_done", 1000);
      check("t6_marker_init_done", 32'(init_done), 1);
      check("t6_marker_drained", 32'(exp_q.size()), 0);
      rom[3] = {8'h72, 8'd19, 8'h5A};

      // hot-plug low clears init_done
      hpd = 1'b0;
      @(negedge clock);
      check("hpd_low_init_done", 32'(init_done), 0);

      // reset while waiting on the engine
      push_range(0, 19);
      pulse_start();
      n = 0;
      while (state_dbg != 3'd4 && n < 200) begin @(negedge clock); n++; end
      check("t6_reached_wait", 32'(state_dbg), 4);
      reset_n = 1'b0;
      @(negedge clock);
      exp_q.delete();
      check("rr_busy", 32'(busy), 0);
      check("rr_state", 32'(state_dbg), 0);
      check("rr_valid", 32'(bus.eng_cmd_valid), 0);
      check("rr_cmd_data", 32'(bus.eng_cmd_data), 0);
      check("rr_ready", 32'(bus.host_req_ready), 0);
      check("rr_rsp", 32'({bus.host_rsp_valid, bus.host_rsp_err}), 0);
      check("rr_status", 32'({init_done, fault}), 0);
      check("rr_fault_index", 32'(fault_index), 0);
      check("rr_tbl_addr", 32'(tbl_addr), 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clock);
      check("post_reset_idle", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
